// File: rtl/rect_fill_writer.sv
// Rectangle fill engine: accepts one fill command, clips it to the visible
// frame and streams one registered pixel write per clock in raster order.
module rect_fill_writer #(
  parameter int unsigned W_RES = 640,
  parameter int unsigned H_RES = 480,
  parameter int unsigned DIM_W = 7
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [10:0]      req_x,
  input  logic [10:0]      req_y,
  input  logic [DIM_W-1:0] req_w,
  input  logic [DIM_W-1:0] req_h,
  input  logic [7:0]       req_r,
  input  logic [7:0]       req_g,
  input  logic [7:0]       req_b,
  output logic             wr_en,
  output logic [10:0]      wr_x,
  output logic [10:0]      wr_y,
  output logic [7:0]       wr_r,
  output logic [7:0]       wr_g,
  output logic [7:0]       wr_b,
  output logic             busy,
  output logic             done
);

  localparam logic [11:0] XMax = 12'(W_RES - 1);
  localparam logic [11:0] YMax = 12'(H_RES - 1);

  typedef enum logic [1:0] {StIdle, StClip, StFill, StDone} state_e;

  state_e           state_q, state_d;
  logic [10:0]      x0_q, y0_q;
  logic [DIM_W-1:0] w_q, h_q;
  logic [7:0]       r_q, g_q, b_q;
  logic [10:0]      x_last_q, y_last_q;
  logic [10:0]      cur_x_q, cur_y_q;

  logic [11:0]      x_end, y_end;
  logic [10:0]      x_last_d, y_last_d;
  logic             empty;
  logic             at_row_end;
  logic             at_last;

  // Clip arithmetic on the latched command; 12 bits so x + w cannot wrap.
  always_comb begin
    x_end    = {1'b0, x0_q} + 12'(w_q) - 12'd1;
    y_end    = {1'b0, y0_q} + 12'(h_q) - 12'd1;
    x_last_d = (x_end > XMax) ? XMax[10:0] : x_end[10:0];
    y_last_d = (y_end > YMax) ? YMax[10:0] : y_end[10:0];
    empty    = (w_q == '0) || (h_q == '0) ||
               ({1'b0, x0_q} > XMax) || ({1'b0, y0_q} > YMax);
  end

  assign at_row_end = (cur_x_q == x_last_q);
  assign at_last    = at_row_end && (cur_y_q == y_last_q);
  assign req_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_valid) state_d = StClip;
      StClip: state_d = empty ? StDone : StFill;
      StFill: if (at_last) state_d = StDone;
      StDone: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Capture the command on acceptance; inputs are ignored afterwards.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      x0_q <= '0;
      y0_q <= '0;
      w_q  <= '0;
      h_q  <= '0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else if (state_q == StIdle && req_valid) begin
      x0_q <= req_x;
      y0_q <= req_y;
      w_q  <= req_w;
      h_q  <= req_h;
      r_q  <= req_r;
      g_q  <= req_g;
      b_q  <= req_b;
    end
  end

  // Clip bounds and raster cursor.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      x_last_q <= '0;
      y_last_q <= '0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
    end else if (state_q == StClip) begin
      x_last_q <= x_last_d;
      y_last_q <= y_last_d;
      cur_x_q  <= x0_q;
      cur_y_q  <= y0_q;
    end else if (state_q == StFill) begin
      if (at_row_end) begin
        cur_x_q <= x0_q;
        cur_y_q <= cur_y_q + 11'd1;
      end else begin
        cur_x_q <= cur_x_q + 11'd1;
      end
    end
  end

  // Registered write port and completion pulse; each lags its state by one cycle.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      wr_en <= 1'b0;
      wr_x  <= '0;
      wr_y  <= '0;
      wr_r  <= '0;
      wr_g  <= '0;
      wr_b  <= '0;
      done  <= 1'b0;
    end else begin
      wr_en <= (state_q == StFill);
      done  <= (state_q == StDone);
      if (state_q == StFill) begin
        wr_x <= cur_x_q;
        wr_y <= cur_y_q;
        wr_r <= r_q;
        wr_g <= g_q;
        wr_b <= b_q;
      end
    end
  end

endmodule

// File: tb/tb_rect_fill_writer.sv
// Directed bench for rect_fill_writer: logs every write and done pulse with
// its cycle number, then compares against hand-computed expectations.
module tb_rect_fill_writer;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [10:0] req_x = '0, req_y = '0;
  logic [6:0]  req_w = '0, req_h = '0;
  logic [7:0]  req_r = '0, req_g = '0, req_b = '0;
  logic        wr_en;
  logic [10:0] wr_x, wr_y;
  logic [7:0]  wr_r, wr_g, wr_b;
  logic        busy, done;

  rect_fill_writer #(.W_RES(640), .H_RES(480), .DIM_W(7)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x    (req_x),
    .req_y    (req_y),
    .req_w    (req_w),
    .req_h    (req_h),
    .req_r    (req_r),
    .req_g    (req_g),
    .req_b    (req_b),
    .wr_en    (wr_en),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .wr_r     (wr_r),
    .wr_g     (wr_g),
    .wr_b     (wr_b),
    .busy     (busy),
    .done     (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [45:0] wq[$];
  int          wc[$];

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Write/done log, sampled mid-cycle.
  always @(negedge CLOCK_50) begin
    if (wr_en) begin
      wq.push_back({wr_x, wr_y, wr_r, wr_g, wr_b});
      wc.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [45:0] pix(input int x, input int y, input logic [23:0] rgb);
    logic [10:0] xx, yy;
    xx = 11'(x);
    yy = 11'(y);
    return {xx, yy, rgb};
  endfunction

  function automatic logic [45:0] wr_at(input int idx);
    if (idx < wq.size()) return wq[idx];
    return '1;
  endfunction

  // Drive one command for a single accepting edge; returns the acceptance cycle.
  task automatic send(input int x, input int y, input int w, input int h,
                      input logic [23:0] rgb, output int acc);
    @(negedge CLOCK_50);
    req_x = 11'(x); req_y = 11'(y); req_w = 7'(w); req_h = 7'(h);
    {req_r, req_g, req_b} = rgb;
    req_valid = 1'b1;
    @(negedge CLOCK_50);
    req_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge CLOCK_50);
      #1;
      n++;
    end
    if (done_cnt < target) check("done_timeout", 64'(done_cnt), 64'(target));
  endtask

  initial begin
    int acc, b, d0, k, n;
    logic [23:0] red, col;
    red = 24'hFF0000;

    // Reset state
    #2;
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_wr_data", {18'd0, wr_x, wr_y, wr_r, wr_g, wr_b}, 64'd0);
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b1;

    // 4x2 fill at (10,20), red
    b = wq.size(); d0 = done_cnt;
    send(10, 20, 4, 2, red, acc);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_ready_busy", 64'(req_ready), 64'd0);
    wait_done(d0 + 1, 50);
    check("t1_count", 64'(wq.size() - b), 64'd8);
    k = 0;
    for (int y = 20; y <= 21; y++)
      for (int x = 10; x <= 13; x++) begin
        check("t1_pix", wr_at(b + k), pix(x, y, red));
        k++;
      end
    if (wq.size() - b == 8) begin
      check("t1_first_lat", 64'(wc[b] - acc), 64'd2);
      check("t1_consec", 64'(wc[b + 7] - wc[b]), 64'd7);
      check("t1_done_lat", 64'(done_cyc - wc[b + 7]), 64'd1);
    end
    @(negedge CLOCK_50); #1;
    check("t1_ready_after", 64'(req_ready), 64'd1);
    check("t1_done_pulse", 64'(done), 64'd0);
    check("t1_done_once", 64'(done_cnt - d0), 64'd1);

    // Corner clip at (638,478) 4x4
    col = 24'h00FF00;
    b = wq.size(); d0 = done_cnt;
    send(638, 478, 4, 4, col, acc);
    wait_done(d0 + 1, 50);
    check("t2_count", 64'(wq.size() - b), 64'd4);
    check("t2_p0", wr_at(b), pix(638, 478, col));
    check("t2_p1", wr_at(b + 1), pix(639, 478, col));
    check("t2_p2", wr_at(b + 2), pix(638, 479, col));
    check("t2_p3", wr_at(b + 3), pix(639, 479, col));

    // Empty: w=0
    b = wq.size(); d0 = done_cnt;
    send(5, 5, 0, 3, 24'h123456, acc);
    wait_done(d0 + 1, 20);
    check("t3_w0_count", 64'(wq.size() - b), 64'd0);
    check("t3_w0_done_lat", 64'(done_cyc - acc), 64'd2);

    // Empty: x off-screen
    b = wq.size(); d0 = done_cnt;
    send(700, 5, 3, 3, 24'h654321, acc);
    wait_done(d0 + 1, 20);
    check("t3_x700_count", 64'(wq.size() - b), 64'd0);
    check("t3_x700_done_lat", 64'(done_cyc - acc), 64'd2);

    // Valid held high across two commands
    b = wq.size(); d0 = done_cnt;
    @(negedge CLOCK_50);
    req_x = 11'd100; req_y = 11'd100; req_w = 7'd2; req_h = 7'd2;
    {req_r, req_g, req_b} = 24'h0000FF;
    req_valid = 1'b1;
    @(posedge CLOCK_50); #1;
    req_x = 11'd200; req_y = 11'd50; req_w = 7'd3; req_h = 7'd1;
    {req_r, req_g, req_b} = 24'hABCDEF;
    wait_done(d0 + 2, 60);
    req_valid = 1'b0;
    repeat (6) @(negedge CLOCK_50);
    #1;
    check("t4_count", 64'(wq.size() - b), 64'd7);
    check("t4_p0", wr_at(b), pix(100, 100, 24'h0000FF));
    check("t4_p1", wr_at(b + 1), pix(101, 100, 24'h0000FF));
    check("t4_p2", wr_at(b + 2), pix(100, 101, 24'h0000FF));
    check("t4_p3", wr_at(b + 3), pix(101, 101, 24'h0000FF));
    check("t4_p4", wr_at(b + 4), pix(200, 50, 24'hABCDEF));
    check("t4_p5", wr_at(b + 5), pix(201, 50, 24'hABCDEF));
    check("t4_p6", wr_at(b + 6), pix(202, 50, 24'hABCDEF));
    if (wq.size() - b == 7) check("t4_gap", 64'(wc[b + 4] - wc[b + 3]), 64'd4);
    check("t4_done_cnt", 64'(done_cnt - d0), 64'd2);
    check("t4_ready", 64'(req_ready), 64'd1);

    // Asynchronous reset during the 5th write of a 16x16 fill
    b = wq.size(); d0 = done_cnt;
    send(30, 40, 16, 16, 24'h808080, acc);
    n = 0;
    while (wq.size() - b < 5 && n < 40) begin
      @(negedge CLOCK_50); #1;
      n++;
    end
    check("t5_reached_5th", 64'(wq.size() - b), 64'd5);
    check("t5_5th_live", 64'(wr_en), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_abort_wr_en", 64'(wr_en), 64'd0);
    check("t5_abort_ready", 64'(req_ready), 64'd1);
    check("t5_abort_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    #1;
    check("t5_no_more_writes", 64'(wq.size() - b), 64'd5);
    check("t5_no_done", 64'(done_cnt - d0), 64'd0);
    check("t5_ready_after", 64'(req_ready), 64'd1);
    b = wq.size();
    send(0, 0, 1, 1, 24'h010203, acc);
    wait_done(d0 + 1, 20);
    check("t5_1x1_count", 64'(wq.size() - b), 64'd1);
    check("t5_1x1_pix", wr_at(b), pix(0, 0, 24'h010203));

    // Maximum 127x127 at origin
    b = wq.size(); d0 = done_cnt;
    send(0, 0, 127, 127, 24'hC0FFEE, acc);
    wait_done(d0 + 1, 20000);
    check("t6_count", 64'(wq.size() - b), 64'd16129);
    check("t6_first", wr_at(b), pix(0, 0, 24'hC0FFEE));
    check("t6_second_row", wr_at(b + 127), pix(0, 1, 24'hC0FFEE));
    check("t6_last", wr_at(b + 16128), pix(126, 126, 24'hC0FFEE));
    if (wq.size() - b == 16129) begin
      check("t6_consec", 64'(wc[b + 16128] - wc[b]), 64'd16128);
      check("t6_done_lat", 64'(done_cyc - wc[b + 16128]), 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
